// File: rtl/dfe_pkg.sv
// dfe_pkg - shared definitions for the fractional 2/3 decimator.
//   DATA_W/COEF_W/ACC_W : default sample, coefficient and accumulator widths
//   TAPS_PP             : taps per polyphase branch
//   H[phase][tap]       : polyphase coefficients, s16.15
//   state_t             : control FSM states
package dfe_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 36;
  localparam int TAPS_PP   = 6;
  localparam int PHASES    = 2;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int TAP_W     = $clog2(TAPS_PP);
  localparam int FRAC_BITS = COEF_W - 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Each branch sums to exactly 32768 so both output phases have unity DC gain.
  localparam coef_t H [PHASES][TAPS_PP] = '{
    '{-16'sd1024, 16'sd3584, 16'sd13824, 16'sd13824, 16'sd3584, -16'sd1024},
    '{-16'sd768,  16'sd2048, 16'sd15104, 16'sd15104, 16'sd2048, -16'sd768 }
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

endpackage

// File: rtl/frac_decimator_2_3_if.sv
// frac_decimator_2_3_if - sample stream bundle of the 2/3 decimator.
//   din_valid/din   : input strobe and signed sample (source -> decimator)
//   dout_valid/dout : output strobe and signed sample (decimator -> sink)
//   busy            : MAC running
//   ovf             : sticky overrun flag
// Modports: master = sample source / observer, slave = decimator.
interface frac_decimator_2_3_if;
  import dfe_pkg::*;

  logic                     din_valid;
  logic signed [DATA_W-1:0] din;
  logic                     dout_valid;
  logic signed [DATA_W-1:0] dout;
  logic                     busy;
  logic                     ovf;

  modport master (
    output din_valid, din,
    input  dout_valid, dout, busy, ovf
  );

  modport slave (
    input  din_valid, din,
    output dout_valid, dout, busy, ovf
  );

endinterface

// File: rtl/frac_dec_mac.sv
// frac_dec_mac - serial multiply-accumulate with round and output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear accumulator (MAC entry)
//   en         : accumulate x*coef this cycle
//   rnd        : round the accumulator and register it to dout
//   x, coef    : signed sample and coefficient operands
//   dout       : rounded result, held between strobes
//   dout_valid : one-cycle strobe with each new dout
// Build option: FRAC_DEC_SAT_EN defined -> saturate to DATA_W,
//               undefined -> keep the low DATA_W bits (wrap).
module frac_dec_mac
  import dfe_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     rnd,
  input  logic signed [DATA_W-1:0] x,
  input  coef_t                    coef,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC_BITS - 1));

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  // Round half up in s.15, arithmetic shift back to integer sample scale.
  function automatic logic signed [ACC_W-1:0] round_q15(input logic signed [ACC_W-1:0] a);
    return (a + RND_HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [DATA_W-1:0] limit(input logic signed [ACC_W-1:0] a);
`ifdef FRAC_DEC_SAT_EN
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'((1 << (DATA_W - 1)) - 1);
    lo = ~hi;
    if (a > hi)
      return hi[DATA_W-1:0];
    else if (a < lo)
      return lo[DATA_W-1:0];
    else
      return a[DATA_W-1:0];
`else
    return a[DATA_W-1:0];
`endif
  endfunction

  // Stage 0: full-precision signed product
  assign prod_p0 = x * coef;

  // Stage 1: accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_p1 + ACC_W'(prod_p0);
    end
  end

  // Stage 2: round / limit into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rnd;
      if (rnd) begin
        dout <= limit(round_q15(acc_p1));
      end
    end
  end

endmodule

// File: rtl/frac_decimator_2_3.sv
// frac_decimator_2_3 - fractional 2/3 sample-rate converter (9 -> 6 MS/s).
// A 6-deep delay line feeds a 2-phase, 6-tap polyphase FIR evaluated by one
// serial MAC. Of every three accepted inputs the first two start a MAC
// (phase 0 then phase 1); the third only shifts.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of frac_decimator_2_3_if
//           (din_valid, din, dout_valid, dout, busy, ovf)
// Build option: FRAC_DEC_SAT_EN selects saturating output (see frac_dec_mac).
module frac_decimator_2_3
  import dfe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  frac_decimator_2_3_if.slave  bus
);

  localparam logic [1:0]       PH_SKIP  = 2'd2;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS_PP - 1);

  logic signed [DATA_W-1:0] xd [TAPS_PP];
  logic [1:0]               ph_cnt;
  state_t                   state;
  logic [TAP_W-1:0]         tap;
  logic                     phase;
  logic                     busy_r;
  logic                     ovf_r;

  logic                     accept;
  logic                     start_mac;
  logic                     mac_en;
  logic                     rnd_en;
  logic signed [DATA_W-1:0] x_sel;
  coef_t                    c_sel;
  logic signed [DATA_W-1:0] mac_dout;
  logic                     mac_dout_valid;

  // Inputs are only taken in IDLE; anything arriving during MAC/ROUND is lost.
  assign accept    = bus.din_valid && (state == ST_IDLE);
  assign start_mac = accept && (ph_cnt != PH_SKIP);
  assign mac_en    = (state == ST_MAC);
  assign rnd_en    = (state == ST_ROUND);

  // The delay line is frozen while busy, so the MAC reads the post-shift taps.
  assign x_sel = xd[tap];
  assign c_sel = H[phase][tap];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ph_cnt <= '0;
      tap    <= '0;
      phase  <= 1'b0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      for (int i = 0; i < TAPS_PP; i++) begin
        xd[i] <= '0;
      end
    end else begin
      if (bus.din_valid && (state != ST_IDLE)) begin
        ovf_r <= 1'b1;
      end

      if (accept) begin
        xd[0] <= bus.din;
        for (int i = 1; i < TAPS_PP; i++) begin
          xd[i] <= xd[i-1];
        end
        ph_cnt <= (ph_cnt == PH_SKIP) ? 2'd0 : ph_cnt + 2'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start_mac) begin
            state  <= ST_MAC;
            tap    <= '0;
            phase  <= ph_cnt[0];
            busy_r <= 1'b1;
          end
        end
        ST_MAC: begin
          if (tap == TAP_LAST) begin
            state <= ST_ROUND;
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        ST_ROUND: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  frac_dec_mac u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_mac),
    .en         (mac_en),
    .rnd        (rnd_en),
    .x          (x_sel),
    .coef       (c_sel),
    .dout       (mac_dout),
    .dout_valid (mac_dout_valid)
  );

  assign bus.dout       = mac_dout;
  assign bus.dout_valid = mac_dout_valid;
  assign bus.busy       = busy_r;
  assign bus.ovf        = ovf_r;

endmodule
